// File: rtl/move_entry_ctrl.sv
// Purpose: synchronize/debounce raw enter_L and newGame_L, and turn each enter press into one moveValid or moveErr pulse.
// Latency: a raw edge sampled at edge k yields its output pulse registered at edge k+2+DEBOUNCE_CYCLES.
// Backpressure: none; a press seen while ready is low is consumed as moveErr and is not retried.
module move_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enter_L,
    input  logic       newGame_L,
    input  logic [3:0] hMove,
    input  logic [8:0] taken,
    input  logic       ready,
    output logic       moveValid,
    output logic [3:0] moveOut,
    output logic       moveErr,
    output logic       newGame
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    // Synchronizer flops (released level is 1)
    logic enter_s1_q, enter_s2_q, ng_s1_q, ng_s2_q;
    // Debouncer state
    logic          enter_db_q, enter_db_d;
    logic [CW-1:0] enter_cnt_q, enter_cnt_d;
    logic          ng_db_q, ng_db_d;
    logic [CW-1:0] ng_cnt_q, ng_cnt_d;
    logic          ng_db_prev_q;
    // FSM and registered outputs
    state_t        state_q, state_d;
    logic          move_valid_q, move_valid_d;
    logic          move_err_q, move_err_d;
    logic          new_game_q, new_game_d;
    logic [3:0]    move_out_q, move_out_d;

    // Combinational helpers for the legality check
    logic       in_range;
    logic [3:0] taken_idx;
    logic       taken_hit;
    logic       move_legal;

    // Two-flop synchronizers for both raw switches
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_s1_q <= 1'b1;
            enter_s2_q <= 1'b1;
            ng_s1_q    <= 1'b1;
            ng_s2_q    <= 1'b1;
        end else begin
            enter_s1_q <= enter_L;
            enter_s2_q <= enter_s1_q;
            ng_s1_q    <= newGame_L;
            ng_s2_q    <= ng_s1_q;
        end
    end

    // Debounce: the level only follows s after DEBOUNCE_CYCLES consecutive differing cycles
    always_comb begin
        enter_db_d  = enter_db_q;
        enter_cnt_d = '0;
        if (enter_s2_q != enter_db_q) begin
            if (enter_cnt_q == CNT_MAX) begin
                enter_db_d = enter_s2_q;
            end else begin
                enter_cnt_d = enter_cnt_q + CW'(1);
            end
        end

        ng_db_d  = ng_db_q;
        ng_cnt_d = '0;
        if (ng_s2_q != ng_db_q) begin
            if (ng_cnt_q == CNT_MAX) begin
                ng_db_d = ng_s2_q;
            end else begin
                ng_cnt_d = ng_cnt_q + CW'(1);
            end
        end
    end

    // Debouncer registers plus delayed newGame level for falling-edge detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            enter_db_q   <= 1'b1;
            enter_cnt_q  <= '0;
            ng_db_q      <= 1'b1;
            ng_cnt_q     <= '0;
            ng_db_prev_q <= 1'b1;
        end else begin
            enter_db_q   <= enter_db_d;
            enter_cnt_q  <= enter_cnt_d;
            ng_db_q      <= ng_db_d;
            ng_cnt_q     <= ng_cnt_d;
            ng_db_prev_q <= ng_db_q;
        end
    end

    // Legal move: ready, hMove in 1..9, and that number not yet taken; the taken lookup is gated by range
    always_comb begin
        in_range   = (hMove != 4'd0) && (hMove <= 4'd9);
        taken_idx  = hMove - 4'd1;
        taken_hit  = 1'b0;
        if (in_range) begin
            taken_hit = taken[taken_idx];
        end
        move_legal = ready && in_range && !taken_hit;
    end

    // Press FSM: one action per debounced press; newGame pre-empts a coincident move
    always_comb begin
        state_d      = state_q;
        move_valid_d = 1'b0;
        move_err_d   = 1'b0;
        move_out_d   = move_out_q;
        new_game_d   = ng_db_prev_q && !ng_db_q;
        unique case (state_q)
            IDLE: begin
                if (!enter_db_q) begin
                    state_d = HELD;
                    if (!new_game_d) begin
                        if (move_legal) begin
                            move_valid_d = 1'b1;
                            move_out_d   = hMove;
                        end else begin
                            move_err_d = 1'b1;
                        end
                    end
                end
            end
            HELD: begin
                if (enter_db_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered output pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            move_valid_q <= 1'b0;
            move_err_q   <= 1'b0;
            new_game_q   <= 1'b0;
            move_out_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            move_valid_q <= move_valid_d;
            move_err_q   <= move_err_d;
            new_game_q   <= new_game_d;
            move_out_q   <= move_out_d;
        end
    end

    assign moveValid = move_valid_q;
    assign moveErr   = move_err_q;
    assign newGame   = new_game_q;
    assign moveOut   = move_out_q;

endmodule

// File: tb/tb_move_entry_ctrl.sv
// Directed bench for move_entry_ctrl with DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Edge index 0 is the first rising edge after the stimulus change.
module tb_move_entry_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       enter_L;
    logic       newGame_L;
    logic [3:0] hMove;
    logic [8:0] taken;
    logic       ready;
    logic       moveValid;
    logic [3:0] moveOut;
    logic       moveErr;
    logic       newGame;

    int errors = 0;
    int checks = 0;

    int edge_idx;
    int v_cnt, e_cnt, ng_cnt, both_cnt;
    int v_edge, e_edge, ng_edge;

    move_entry_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .enter_L   (enter_L),
        .newGame_L (newGame_L),
        .hMove     (hMove),
        .taken     (taken),
        .ready     (ready),
        .moveValid (moveValid),
        .moveOut   (moveOut),
        .moveErr   (moveErr),
        .newGame   (newGame)
    );

    always #5 clock = ~clock;

    task automatic clear_counts();
        edge_idx = -1;
        v_cnt = 0; e_cnt = 0; ng_cnt = 0; both_cnt = 0;
        v_edge = -1; e_edge = -1; ng_edge = -1;
    endtask

    // Advance n edges, tallying output pulses and the edge on which each was seen
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            edge_idx++;
            if (moveValid) begin v_cnt++; v_edge = edge_idx; end
            if (moveErr) begin e_cnt++; e_edge = edge_idx; end
            if (newGame) begin ng_cnt++; ng_edge = edge_idx; end
            if (moveValid && moveErr) both_cnt++;
        end
    endtask

    task automatic release_enter();
        enter_L = 1'b1;
        clear_counts();
        step(10);
        checks++;
        if (v_cnt !== 0 || e_cnt !== 0) begin
            errors++;
            $display("FAIL release_quiet: valid=%0d err=%0d required 0/0", v_cnt, e_cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enter_L = 1'b1; newGame_L = 1'b1;
        hMove = 4'd0; taken = 9'd0; ready = 1'b1;
        #12;
        checks++;
        if (moveValid !== 1'b0 || moveErr !== 1'b0 || newGame !== 1'b0 || moveOut !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b err=%b ng=%b out=%0d required 0/0/0/0",
                     moveValid, moveErr, newGame, moveOut);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        clear_counts();
        step(8);
        checks++;
        if (v_cnt !== 0 || e_cnt !== 0 || ng_cnt !== 0) begin
            errors++;
            $display("FAIL idle_quiet: valid=%0d err=%0d ng=%0d required 0", v_cnt, e_cnt, ng_cnt);
        end
    endtask

    task automatic test_valid_move();
        ready = 1'b1; taken = 9'd0; hMove = 4'd6;
        enter_L = 1'b0;
        clear_counts();
        step(20);
        checks++;
        if (v_cnt !== 1 || v_edge !== 6) begin
            errors++;
            $display("FAIL valid_timing: count=%0d edge=%0d required 1 at edge 6", v_cnt, v_edge);
        end
        checks++;
        if (moveOut !== 4'd6) begin
            errors++;
            $display("FAIL valid_moveout: got %0d required 6", moveOut);
        end
        checks++;
        if (e_cnt !== 0 || both_cnt !== 0) begin
            errors++;
            $display("FAIL valid_no_err: err=%0d both=%0d required 0/0", e_cnt, both_cnt);
        end
        release_enter();
    endtask

    task automatic test_bounce();
        hMove = 4'd6;
        clear_counts();
        enter_L = 1'b0;
        step(3);
        enter_L = 1'b1;
        step(10);
        checks++;
        if (v_cnt !== 0 || e_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_ignored: valid=%0d err=%0d required 0/0", v_cnt, e_cnt);
        end
        enter_L = 1'b0;
        clear_counts();
        step(10);
        checks++;
        if (v_cnt !== 1 || v_edge !== 6 || e_cnt !== 0) begin
            errors++;
            $display("FAIL bounce_then_press: valid=%0d at %0d err=%0d required 1 at 6, 0",
                     v_cnt, v_edge, e_cnt);
        end
        release_enter();
    endtask

    task automatic test_taken();
        taken = 9'b000010000; hMove = 4'd5; ready = 1'b1;
        enter_L = 1'b0;
        clear_counts();
        step(10);
        checks++;
        if (e_cnt !== 1 || e_edge !== 6 || v_cnt !== 0) begin
            errors++;
            $display("FAIL taken_err: err=%0d at %0d valid=%0d required 1 at 6, 0", e_cnt, e_edge, v_cnt);
        end
        checks++;
        if (moveOut !== 4'd6) begin
            errors++;
            $display("FAIL taken_moveout_kept: got %0d required 6", moveOut);
        end
        release_enter();
        hMove = 4'd9;
        enter_L = 1'b0;
        clear_counts();
        step(10);
        checks++;
        if (v_cnt !== 1 || e_cnt !== 0 || moveOut !== 4'd9) begin
            errors++;
            $display("FAIL taken_other_ok: valid=%0d err=%0d out=%0d required 1/0/9", v_cnt, e_cnt, moveOut);
        end
        release_enter();
    endtask

    task automatic test_errors();
        logic [3:0] mv_tab [3];
        logic       rdy_tab [3];
        mv_tab[0] = 4'd0;  rdy_tab[0] = 1'b1;
        mv_tab[1] = 4'd12; rdy_tab[1] = 1'b1;
        mv_tab[2] = 4'd3;  rdy_tab[2] = 1'b0;
        taken = 9'd0;
        for (int c = 0; c < 3; c++) begin
            hMove = mv_tab[c]; ready = rdy_tab[c];
            enter_L = 1'b0;
            clear_counts();
            step(8);
            // raising ready while still held must not retry the consumed press
            ready = 1'b1;
            step(4);
            checks++;
            if (e_cnt !== 1 || v_cnt !== 0 || both_cnt !== 0) begin
                errors++;
                $display("FAIL err_case%0d: err=%0d valid=%0d required 1/0", c, e_cnt, v_cnt);
            end
            checks++;
            if (moveOut !== 4'd9) begin
                errors++;
                $display("FAIL err_case%0d_moveout: got %0d required 9", c, moveOut);
            end
            release_enter();
        end
    endtask

    task automatic test_newgame_priority();
        hMove = 4'd2; taken = 9'd0; ready = 1'b1;
        enter_L = 1'b0; newGame_L = 1'b0;
        clear_counts();
        step(12);
        checks++;
        if (ng_cnt !== 1 || ng_edge !== 6) begin
            errors++;
            $display("FAIL ng_pulse: count=%0d edge=%0d required 1 at 6", ng_cnt, ng_edge);
        end
        checks++;
        if (v_cnt !== 0 || e_cnt !== 0) begin
            errors++;
            $display("FAIL ng_wins: valid=%0d err=%0d required 0/0", v_cnt, e_cnt);
        end
        enter_L = 1'b1; newGame_L = 1'b1;
        clear_counts();
        step(10);
        checks++;
        if (ng_cnt !== 0 || v_cnt !== 0 || e_cnt !== 0) begin
            errors++;
            $display("FAIL ng_release_quiet: ng=%0d valid=%0d err=%0d required 0", ng_cnt, v_cnt, e_cnt);
        end
        enter_L = 1'b0;
        clear_counts();
        step(10);
        checks++;
        if (v_cnt !== 1 || moveOut !== 4'd2) begin
            errors++;
            $display("FAIL ng_back_to_idle: valid=%0d out=%0d required 1/2", v_cnt, moveOut);
        end
        release_enter();
    endtask

    task automatic test_reset_mid_press();
        hMove = 4'd4; ready = 1'b1; taken = 9'd0;
        enter_L = 1'b0;
        clear_counts();
        step(10);
        checks++;
        if (v_cnt !== 1 || moveOut !== 4'd4) begin
            errors++;
            $display("FAIL pre_reset_press: valid=%0d out=%0d required 1/4", v_cnt, moveOut);
        end
        reset = 1'b1;
        #2;
        checks++;
        if (moveValid !== 1'b0 || moveErr !== 1'b0 || newGame !== 1'b0 || moveOut !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: valid=%b err=%b ng=%b out=%0d required 0/0/0/0",
                     moveValid, moveErr, newGame, moveOut);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        clear_counts();
        step(12);
        checks++;
        if (v_cnt !== 1 || v_edge !== 6 || moveOut !== 4'd4 || e_cnt !== 0) begin
            errors++;
            $display("FAIL post_reset_repress: valid=%0d at %0d out=%0d err=%0d required 1 at 6, 4, 0",
                     v_cnt, v_edge, moveOut, e_cnt);
        end
        release_enter();
    endtask

    initial begin
        test_reset();
        test_valid_move();
        test_bounce();
        test_taken();
        test_errors();
        test_newgame_priority();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/move_entry_ctrl.md
Name: move_entry_ctrl

Overview:
- Front-end stage directly upstream of the game-control FSM; conditions the raw human-player controls before they reach it.
- Synchronizes and debounces the raw active-low enter_L and newGame_L switches.
- Turns each enter press into exactly one validated-move pulse or one error pulse, after checking hMove against the legal range 1..9 and against the game's taken-number mask.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized input must differ from its debounced value before the debounced value changes. Legal range is 1..65535. Counter width is $clog2(DEBOUNCE_CYCLES+1).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enter_L  input  1  raw enter switch, active low, asynchronous to clock.
- newGame_L  input  1  raw new-game switch, active low, asynchronous to clock.
- hMove  input  4  human move number, sampled at press acceptance.
- taken  input  9  bit i set means number i+1 is already played (from game FSM).
- ready  input  1  game FSM can accept a human move this cycle.
- moveValid  output  1  one-cycle pulse: legal move accepted.
- moveOut  output  4  captured move; stable from the moveValid pulse until the next accepted press.
- moveErr  output  1  one-cycle pulse: press rejected.
- newGame  output  1  one-cycle pulse: new-game request.

Behaviour:
- Reset (async, high):
  - Sync flops and debounced levels go to 1 (released).
  - Debounce counters go to 0 and the FSM goes to IDLE.
  - moveValid, moveErr, newGame and moveOut go to 0.
- Synchronizer: two flops per raw input. Let s be the second-flop output.
- Debouncer, per input:
  - If s equals the debounced value, count is cleared to 0.
  - Otherwise, if count equals DEBOUNCE_CYCLES-1, the debounced value is loaded with s and count is cleared.
  - Otherwise count increments.
  - Any bounce shorter than DEBOUNCE_CYCLES cycles is ignored.
- Latency:
  - A raw change sampled at edge k updates the debounced level at edge k+1+DEBOUNCE_CYCLES.
  - The resulting output pulse is registered at edge k+2+DEBOUNCE_CYCLES and is high for exactly one cycle.
- FSM states: IDLE and HELD.
  - IDLE, debounced enter pressed (0): capture hMove and go to HELD.
    - Legal if ready=1, 1<=hMove<=9 and taken[hMove-1]=0. Then moveOut <= hMove and moveValid is pulsed.
    - Otherwise moveErr is pulsed and moveOut is unchanged.
  - HELD: no further pulses. Return to IDLE on the cycle the debounced enter reads released (1). One action per physical press.
- newGame:
  - A debounced newGame_L falling edge pulses newGame once. It is independent of FSM state.
  - On the same cycle as an IDLE enter press, newGame wins: no moveValid or moveErr is issued, and the FSM still goes to HELD, so the press is consumed.
- moveValid and moveErr are never high together.
- hMove = 0 or hMove >= 10: moveErr. No taken-bit lookup is performed, so there is no out-of-range index.
- ready low at acceptance: moveErr. The press is consumed; it is not retried when ready rises.
- Reset mid-press: the FSM returns to IDLE with the debounced level released. A switch still held after reset deasserts is re-debounced and treated as a new press.
- Debounced enter released and pressed again without settling: impossible by construction. Each transition needs DEBOUNCE_CYCLES stable cycles.

Test Plan:
1. DEBOUNCE_CYCLES=4, ready=1, taken=0, hMove=6; enter_L falls before edge 0 and is held 20 cycles -> moveValid high only between edges 6 and 7, moveOut=6, moveErr never high.
2. enter_L pulses low for 3 cycles, then high -> no moveValid, moveErr or state change. Then held low 10 cycles -> exactly one moveValid.
3. taken=9'b000010000 (number 5 played), hMove=5 -> single moveErr pulse, moveOut keeps its prior value. Then hMove=9 on a new press -> moveValid, moveOut=9.
4. hMove=0, then hMove=12, then ready=0 with hMove=3, each on a separate press -> three moveErr pulses, zero moveValid.
5. newGame_L and enter_L fall on the same cycle -> newGame pulse at edge 6, no move pulse. Releasing enter returns the FSM to IDLE.
6. Assert reset while enter is held in HELD, then release reset with enter still low -> all outputs 0 during reset. One moveValid 2+DEBOUNCE_CYCLES edges after reset deasserts.
